// File: rtl/arb_pkg.sv
// Shared arbiter types and helpers.
// Used by rr_arb_idx and the index-to-one-hot decoder.
package arb_pkg;

   typedef enum logic {
      ARB_IDLE,
      ARB_GRANT
   } arb_state_t;

   // Index width that never collapses to zero for a single requester.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arb_idx_if.sv
// Request / grant-index handshake bundle.
// master = arbiter side, slave = requesters plus consumer side.
interface rr_arb_idx_if
   import arb_pkg::*;
#(
   parameter int NUM_REQ = 4
);

   localparam int INDEX_WIDTH = idx_w(NUM_REQ);

   logic [NUM_REQ-1:0]     req;
   logic                   grant_valid;
   logic [INDEX_WIDTH-1:0] grant_idx;
   logic                   grant_ready;
   logic                   grant_last;

   modport master (
      input  req,
      input  grant_ready,
      input  grant_last,
      output grant_valid,
      output grant_idx
   );

   modport slave (
      output req,
      output grant_ready,
      output grant_last,
      input  grant_valid,
      input  grant_idx
   );

endinterface

// File: rtl/rr_pick.sv
// Circular first-set-bit search starting at ptr.
// Double-width masked priority encode, no power-of-2 wrap.
module rr_pick
   import arb_pkg::*;
#(
   parameter  int NUM_REQ     = 4,
   localparam int INDEX_WIDTH = idx_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0]     req_i,
   input  logic [INDEX_WIDTH-1:0] ptr_i,
   output logic                   found_o,
   output logic [INDEX_WIDTH-1:0] idx_o
);

   logic [2*NUM_REQ-1:0] dbl;
   logic [2*NUM_REQ-1:0] masked;

   assign dbl = {req_i, req_i};

   // Drop bits below ptr; the upper copy supplies the wrapped part.
   always_comb begin
      masked = '0;
      for (int j = 0; j < 2*NUM_REQ; j++) begin
         masked[j] = dbl[j] && (j >= int'(ptr_i));
      end
   end

   // Lowest surviving bit wins; fold upper half back onto 0..NUM_REQ-1.
   always_comb begin
      found_o = 1'b0;
      idx_o   = '0;
      for (int j = 2*NUM_REQ-1; j >= 0; j--) begin
         if (masked[j]) begin
            found_o = 1'b1;
            idx_o   = (j >= NUM_REQ) ? INDEX_WIDTH'(j - NUM_REQ)
                                     : INDEX_WIDTH'(j);
         end
      end
   end

endmodule

// File: rtl/rr_arb_idx.sv
// Round-robin arbiter producing a registered grant index.
// Grant is locked until the beat flagged last is accepted.
module rr_arb_idx
   import arb_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input logic           clk,
   input logic           rst_n,
   rr_arb_idx_if.master  bus
);

   localparam int INDEX_WIDTH = idx_w(NUM_REQ);

   arb_state_t             state_q, state_d;
   logic [INDEX_WIDTH-1:0] idx_q, idx_d;
   logic [INDEX_WIDTH-1:0] ptr_q, ptr_d;
   logic [INDEX_WIDTH-1:0] ptr_inc;
   logic [INDEX_WIDTH-1:0] pick_idx;
   logic                   pick_found;
   logic                   accept_last;

   assign accept_last = (state_q == ARB_GRANT)
                      && bus.grant_ready
                      && bus.grant_last;

   // Pointer advances past the winner, wrapping at NUM_REQ-1.
   assign ptr_inc = (idx_q == INDEX_WIDTH'(NUM_REQ-1))
                  ? '0
                  : idx_q + INDEX_WIDTH'(1);

   assign ptr_d = accept_last ? ptr_inc : ptr_q;

   // Searching from ptr_d gives same-cycle re-arbitration on last accept.
   rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .req_i   (bus.req),
      .ptr_i   (ptr_d),
      .found_o (pick_found),
      .idx_o   (pick_idx)
   );

   // Next-state and next grant index.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      unique case (state_q)
         ARB_IDLE: begin
            if (pick_found) begin
               state_d = ARB_GRANT;
               idx_d   = pick_idx;
            end
         end
         ARB_GRANT: begin
            if (accept_last) begin
               if (pick_found) begin
                  idx_d = pick_idx;
               end else begin
                  state_d = ARB_IDLE;
               end
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   // State, grant index and round-robin pointer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ARB_IDLE;
         idx_q   <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
      end
   end

   assign bus.grant_valid = (state_q == ARB_GRANT);
   assign bus.grant_idx   = idx_q;

`ifndef SYNTHESIS
   // The granted requester must hold req until its last beat is taken.
   a_req_held: assert property (
      @(posedge clk) disable iff (!rst_n)
      (state_q == ARB_GRANT && !accept_last) |-> bus.req[idx_q]
   ) else $warning("rr_arb_idx: granted requester dropped req");
`endif

endmodule

// File: tb/tb_rr_arb_idx.sv
// Bench for rr_arb_idx: vector table on NUM_REQ=4,
// hand sequences for async reset and NUM_REQ=3 wrap.
module tb_rr_arb_idx;
   import arb_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   rr_arb_idx_if #(.NUM_REQ(4)) if4 ();
   rr_arb_idx_if #(.NUM_REQ(3)) if3 ();

   rr_arb_idx #(.NUM_REQ(4)) dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if4)
   );

   rr_arb_idx #(.NUM_REQ(3)) dut3 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if3)
   );

   typedef struct {
      logic [3:0] req;
      logic       rdy;
      logic       last;
      logic       ev;
      logic [1:0] ei;
   } vec_t;

   typedef struct {
      logic       v;
      logic       ci;
      logic [1:0] i;
      string      name;
   } exp_t;

   exp_t sbq[$];
   vec_t tbl[20];
   int   checks = 0;
   int   errors = 0;

   task automatic push_exp(input logic v, input logic ci,
                           input logic [1:0] i, input string nm);
      exp_t e;
      e.v = v;
      e.ci = ci;
      e.i = i;
      e.name = nm;
      sbq.push_back(e);
   endtask

   task automatic check_exp(input logic av, input logic [1:0] ai);
      exp_t e;
      checks++;
      if (sbq.size() == 0) begin
         errors++;
         $display("FAIL sb_empty: no expected entry");
         return;
      end
      e = sbq.pop_front();
      if (av !== e.v || (e.ci && ai !== e.i)) begin
         errors++;
         $display("FAIL %s: got valid=%0b idx=%0d, want valid=%0b idx=%0d",
                  e.name, av, ai, e.v, e.i);
      end
   endtask

   task automatic step4(input logic [3:0] r, input logic rdy,
                        input logic lst, input logic ev,
                        input logic [1:0] ei, input string nm);
      if4.req = r;
      if4.grant_ready = rdy;
      if4.grant_last = lst;
      push_exp(ev, ev, ei, nm);
      @(posedge clk);
      #1;
      check_exp(if4.grant_valid, if4.grant_idx);
      @(negedge clk);
   endtask

   task automatic step3(input logic [2:0] r, input logic rdy,
                        input logic lst, input logic ev,
                        input logic [1:0] ei, input string nm);
      if3.req = r;
      if3.grant_ready = rdy;
      if3.grant_last = lst;
      push_exp(ev, ev, ei, nm);
      @(posedge clk);
      #1;
      check_exp(if3.grant_valid, if3.grant_idx);
      checks++;
      if (if3.grant_valid && if3.grant_idx > 2'd2) begin
         errors++;
         $display("FAIL %s_range: got idx=%0d, want idx<3",
                  nm, if3.grant_idx);
      end
      @(negedge clk);
   endtask

   initial begin
      tbl[0]  = '{4'b0100, 1'b1, 1'b1, 1'b1, 2'd2};
      tbl[1]  = '{4'b0000, 1'b1, 1'b1, 1'b0, 2'd0};
      tbl[2]  = '{4'b1111, 1'b1, 1'b1, 1'b1, 2'd3};
      tbl[3]  = '{4'b1111, 1'b1, 1'b1, 1'b1, 2'd0};
      tbl[4]  = '{4'b1111, 1'b1, 1'b1, 1'b1, 2'd1};
      tbl[5]  = '{4'b1111, 1'b1, 1'b1, 1'b1, 2'd2};
      tbl[6]  = '{4'b1111, 1'b1, 1'b1, 1'b1, 2'd3};
      tbl[7]  = '{4'b1111, 1'b1, 1'b1, 1'b1, 2'd0};
      tbl[8]  = '{4'b0011, 1'b1, 1'b0, 1'b1, 2'd0};
      tbl[9]  = '{4'b1000, 1'b1, 1'b0, 1'b1, 2'd0};
      tbl[10] = '{4'b0011, 1'b1, 1'b1, 1'b1, 2'd1};
      tbl[11] = '{4'b1000, 1'b1, 1'b1, 1'b1, 2'd3};
      tbl[12] = '{4'b0101, 1'b0, 1'b1, 1'b1, 2'd3};
      tbl[13] = '{4'b0000, 1'b0, 1'b0, 1'b1, 2'd3};
      tbl[14] = '{4'b1111, 1'b0, 1'b1, 1'b1, 2'd3};
      tbl[15] = '{4'b0010, 1'b0, 1'b1, 1'b1, 2'd3};
      tbl[16] = '{4'b1001, 1'b0, 1'b0, 1'b1, 2'd3};
      tbl[17] = '{4'b0000, 1'b1, 1'b1, 1'b0, 2'd0};
      tbl[18] = '{4'b1111, 1'b0, 1'b0, 1'b1, 2'd0};
      tbl[19] = '{4'b0001, 1'b1, 1'b1, 1'b1, 2'd0};

      if4.req = '0;
      if4.grant_ready = 1'b0;
      if4.grant_last = 1'b0;
      if3.req = '0;
      if3.grant_ready = 1'b0;
      if3.grant_last = 1'b0;

      #12;
      push_exp(1'b0, 1'b1, 2'd0, "reset4");
      check_exp(if4.grant_valid, if4.grant_idx);
      push_exp(1'b0, 1'b1, 2'd0, "reset3");
      check_exp(if3.grant_valid, if3.grant_idx);

      @(negedge clk);
      rst_n = 1'b1;

      for (int k = 0; k < 20; k++) begin
         step4(tbl[k].req, tbl[k].rdy, tbl[k].last,
               tbl[k].ev, tbl[k].ei, $sformatf("vec%0d", k));
      end

      step4(4'b0110, 1'b1, 1'b1, 1'b1, 2'd1, "rst_setup");
      #2;
      rst_n = 1'b0;
      #1;
      push_exp(1'b0, 1'b1, 2'd0, "rst_async");
      check_exp(if4.grant_valid, if4.grant_idx);
      @(negedge clk);
      rst_n = 1'b1;
      step4(4'b0110, 1'b0, 1'b0, 1'b1, 2'd1, "post_rst");

      step3(3'b100, 1'b1, 1'b1, 1'b1, 2'd2, "n3_idx2");
      step3(3'b011, 1'b1, 1'b1, 1'b1, 2'd0, "n3_wrap0");
      step3(3'b011, 1'b1, 1'b1, 1'b1, 2'd1, "n3_idx1");
      step3(3'b011, 1'b1, 1'b1, 1'b1, 2'd0, "n3_again0");
      step3(3'b011, 1'b1, 1'b1, 1'b1, 2'd1, "n3_again1");
      step3(3'b000, 1'b1, 1'b1, 1'b0, 2'd0, "n3_idle");

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/rr_arb_idx.md
Name: rr_arb_idx

Overview:
- Round-robin arbiter over NUM_REQ requesters. Produces a registered grant index with a valid/ready handshake.
- Sits directly upstream of the index-to-one-hot decoder. grant_idx drives the decoder's index input, which produces the mux/select one-hot.
- Supports multi-beat (packet) grants. The grant is locked until the beat flagged last is accepted.

Parameters:
- NUM_REQ, 4, number of requesters (>=1, need not be a power of 2).
- INDEX_WIDTH (localparam), NUM_REQ>1 ? $clog2(NUM_REQ) : 1, width of grant_idx and of the internal pointer.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NUM_REQ  request vector; bit i = requester i.
- grant_valid  output  1  grant_idx is valid.
- grant_idx  output  INDEX_WIDTH  index of the granted requester.
- grant_ready  input  1  consumer accepts the current beat.
- grant_last  input  1  qualifies the accepted beat as the final beat of the granted transfer.

Behaviour:
- Reset (async assert, sync release): grant_valid=0, grant_idx=0, ptr=0, state=IDLE.
- State machine: IDLE, GRANT.
- All outputs come from registers. There is no combinational path from req or grant_ready to any output.
- Winner rule: the first set bit of req scanning upward from ptr, circularly. The index after NUM_REQ-1 is 0, never a power-of-2 wrap.
- IDLE:
  - If |req, go to GRANT next cycle with grant_valid=1 and grant_idx=winner.
  - Latency from req to grant_valid is 1 cycle.
  - If req==0, stay in IDLE with grant_valid=0.
- GRANT: grant_valid=1. grant_idx is held stable until a last beat is accepted.
- Handshake (grant_valid && grant_ready):
  - grant_last=0: stay in GRANT with the same idx.
  - grant_last=1:
    - ptr <= grant_idx+1, wrapped.
    - The new winner is computed in the same cycle from the current req and that updated ptr.
    - If a winner exists, stay in GRANT and load the new idx. This gives back-to-back grants with no bubble.
    - Otherwise go to IDLE and clear grant_valid.
- grant_ready=0: all state is held. Changes on req are ignored while in GRANT.
- Deassertion of req[grant_idx] during GRANT is a protocol violation:
  - The grant is kept until the last beat is accepted.
  - Flagged by a simulation-only assertion.
- grant_ready and grant_last are don't-care when grant_valid=0.
- The same requester can win consecutively only if it is the sole requester. Fairness bound: any held request is granted within NUM_REQ-1 completed transfers.
- NUM_REQ=1:
  - grant_idx is constantly 0 and ptr is a 1-bit register held at 0.
  - Behaviour reduces to a registered valid/ready handshake.
- Reset asserted mid-transfer: outputs clear immediately (asynchronous). No partial state survives.

Decomposition:
- Shared package arb_pkg holds:
  - typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;
  - a function computing the safe index width (max(1, clog2(n))), reused by the decoder and this block.
- One combinational sub-module, rr_pick:
  - Inputs: req[NUM_REQ], ptr[INDEX_WIDTH]. Outputs: found, idx.
  - Implemented as a double-width masked priority encode.
  - Also used for the same-cycle re-arbitration on a last-beat accept.

Test Plan:
- Reset: NUM_REQ=4, req=4'b0110 granted idx1 mid-transfer; pull rst_n low between clock edges -> grant_valid=0 and grant_idx=0 immediately. After release with req=4'b0110 -> idx1 granted 1 cycle later (ptr=0).
- Single requester: req=4'b0100, ready=1, last=1 -> grant_valid=1, idx=2 on cycle 1; after the accept ptr=3; with req=0 -> back to IDLE, grant_valid=0.
- Full load: req=4'b1111 held, ready=1 and last=1 every cycle -> grant_idx sequence 0,1,2,3,0,1 with grant_valid continuously 1 (no bubbles).
- Multi-beat lock: req=4'b0011, ready=1, last=0,0,1 -> idx=0 for three accepted beats, then idx=1 on the next cycle. Also change req to 4'b1000 mid-packet -> idx stays 0.
- Backpressure: granted idx=3, ready=0 for 5 cycles while req toggles randomly -> grant_valid and grant_idx stable every cycle; on ready=1 with last=1 -> ptr=0.
- Non-power-of-2 wrap, NUM_REQ=3: complete a transfer on idx2 (ptr->0) with req=3'b011 -> next grant idx0, then idx1, then idx0. grant_idx never reaches 3.
